score_requester: RTL and testbench
==================================

Name: score_requester

Overview:
- Initiator side of the score-request handshake: the access-controller block that issues score requests to the multi-user scoring block and collects its verdict.
- Captures a finished game (player ID and final score), holds score_request until the scorer answers with valid, and decodes the personal-best and global-high-score flags.
- Holds the result for a display period and buffers one extra game-done event that arrives while busy.

Parameters:
- GUEST_ID, 5'd3, player ID treated as guest; the scorer skips the RAM for it, so pb_out is forced 0.
- TIMEOUT, 1023, cycles to wait for valid before aborting the request.
- HOLD, 255, cycles the result outputs stay asserted after capture.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- game_done  in  1  one-cycle pulse: a game finished; sample game_id and game_score this cycle.
- game_id  in  5  player ID of the finished game.
- game_score  in  7  final score, 0..99.
- valid  in  1  scorer verdict strobe, one cycle.
- pwinner  in  1  scorer personal-best flag, sampled when valid=1.
- gwinner  in  5  scorer global-winner ID, sampled when valid=1.
- score_request  out  1  request to scorer; combinational = req_r & ~valid.
- playerID  out  5  registered ID presented with the request.
- score  out  7  registered score presented with the request.
- busy  out  1  high in REQ or SHOW.
- result_valid  out  1  high for the whole SHOW state.
- pb_out  out  1  personal best achieved (held through SHOW).
- gb_out  out  1  new global high score (held through SHOW).
- timeout_err  out  1  sticky: last request timed out; cleared by the next accepted game_done.
- overflow  out  1  sticky: a game_done was dropped because the pending slot was full; cleared by rst only.

Behaviour:
- Reset (async, rst=1): state IDLE; req_r, result_valid, pb_out, gb_out, timeout_err and overflow are 0; playerID and score are 0; pending slot empty; counters 0.
- States are IDLE, REQ and SHOW.
- IDLE:
  - On game_done, or with the pending slot full, load playerID/score and set req_r=1, then go to REQ.
  - Latency: score_request is high on the cycle after game_done.
  - Pending slot has priority over a simultaneous game_done; that game_done goes into the slot.
- REQ:
  - req_r stays 1; the wait counter increments each cycle.
  - On valid=1, score_request drops in that same cycle (combinational mask), so the scorer, already back in its WAIT state, cannot re-trigger.
  - Also on valid=1: pb_out <= pwinner & (playerID != GUEST_ID); gb_out <= (gwinner == playerID) & (gwinner != 0 | playerID == 0). Player 0 is accepted as a global winner only if a new global score is known; as implemented, gb_out for ID 0 is 1 when gwinner==0 at valid.
  - Also on valid=1: req_r <= 0, result_valid <= 1, hold counter <= 0, go to SHOW.
  - If the wait counter reaches TIMEOUT with no valid: req_r <= 0, timeout_err <= 1, pb_out/gb_out <= 0, return to IDLE.
  - Waiting out the scorer's post-reset RAM initialisation (about 128 cycles) is normal and is not a timeout.
- SHOW:
  - Outputs held; the hold counter increments.
  - When the counter reaches HOLD-1: result_valid, pb_out and gb_out <= 0, go to IDLE.
  - If the pending slot is full, it is serviced on the next IDLE cycle.
- Pending slot (depth 1):
  - A game_done in REQ or SHOW stores ID/score if the slot is empty.
  - If the slot is full, the new event is dropped and overflow <= 1.
  - The slot empties when it is loaded into playerID/score.
- Width: score is 7 bits; values above 99 are forwarded unmodified; no saturation.
- The outputs playerID/score must stay stable for the whole of REQ; they change only on the IDLE->REQ transition.
- valid while in IDLE or SHOW is ignored: no flag update, no state change.

Test Plan:
- Reset, then game_done id=5 score=42; scorer model returns valid with pwinner=1, gwinner=5 after 8 cycles -> score_request is high from cycle 1 and low in the valid cycle; pb_out=1, gb_out=1, result_valid for exactly HOLD cycles; no second request.
- id=3 (guest), score=10; scorer returns valid, pwinner=0, gwinner=3 -> pb_out=0, gb_out=1.
- id=7 score=20; valid with pwinner=0, gwinner=0 -> pb_out=0, gb_out=0, result_valid=1.
- game_done with the scorer model never asserting valid, TIMEOUT=16 -> score_request drops after 16 cycles, timeout_err=1, busy=0; next game_done clears timeout_err.
- Two game_done pulses during REQ (id=1, then id=2) -> id=1 is buffered and requested after the first SHOW ends, id=2 is dropped, overflow=1.
- Assert rst mid-REQ -> score_request=0 and all flags 0 immediately (async); after release the block is in IDLE with the pending slot empty.

Source files
------------

// File: rtl/score_requester.sv
`default_nettype none
// ============================================================================
// score_requester : issues score requests to the scorer and decodes its verdict
// Rev 1.0
// ============================================================================
module score_requester #(
    parameter logic [4:0] GUEST_ID = 5'd3,
    parameter int         TIMEOUT  = 1023,
    parameter int         HOLD     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_done,
    input  logic [4:0] game_id,
    input  logic [6:0] game_score,
    input  logic       valid,
    input  logic       pwinner,
    input  logic [4:0] gwinner,
    output logic       score_request,
    output logic [4:0] playerID,
    output logic [6:0] score,
    output logic       busy,
    output logic       result_valid,
    output logic       pb_out,
    output logic       gb_out,
    output logic       timeout_err,
    output logic       overflow
);

    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);
    localparam int c_HOLD_W = $clog2(HOLD + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_req;
    logic [4:0]          r_player_id;
    logic [6:0]          r_score;
    logic                r_pend_full;
    logic [4:0]          r_pend_id;
    logic [6:0]          r_pend_score;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_result_valid;
    logic                r_pb;
    logic                r_gb;
    logic                r_timeout_err;
    logic                r_overflow;

    logic w_busy;
    logic w_load_slot;
    logic w_load_in;
    logic w_got_valid;
    logic w_timeout;
    logic w_show_end;
    logic w_slot_store;
    logic w_drop;

    assign w_busy = (r_state != S_IDLE);
    // In IDLE a full slot is drained and a simultaneous game_done refills it.
    assign w_slot_store = game_done & ((w_busy & ~r_pend_full) | w_load_slot);
    assign w_drop       = game_done & w_busy & r_pend_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_slot  = 1'b0;
        w_load_in    = 1'b0;
        w_got_valid  = 1'b0;
        w_timeout    = 1'b0;
        w_show_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_full) begin
                    w_load_slot  = 1'b1;
                    w_state_next = S_REQ;
                end else if (game_done) begin
                    w_load_in    = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (valid) begin
                    w_got_valid  = 1'b1;
                    w_state_next = S_SHOW;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_SHOW: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_show_end   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req          <= 1'b0;
            r_player_id    <= '0;
            r_score        <= '0;
            r_pend_full    <= 1'b0;
            r_pend_id      <= '0;
            r_pend_score   <= '0;
            r_wait_cnt     <= '0;
            r_hold_cnt     <= '0;
            r_result_valid <= 1'b0;
            r_pb           <= 1'b0;
            r_gb           <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_load_slot) begin
                r_player_id <= r_pend_id;
                r_score     <= r_pend_score;
            end else if (w_load_in) begin
                r_player_id <= game_id;
                r_score     <= game_score;
            end

            if (w_slot_store) begin
                r_pend_full  <= 1'b1;
                r_pend_id    <= game_id;
                r_pend_score <= game_score;
            end else if (w_load_slot) begin
                r_pend_full <= 1'b0;
            end

            if (w_load_slot || w_load_in) begin
                r_req      <= 1'b1;
                r_wait_cnt <= '0;
            end else if (w_got_valid || w_timeout) begin
                r_req <= 1'b0;
            end else if (r_state == S_REQ) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end

            if (w_got_valid) begin
                r_hold_cnt     <= '0;
                r_result_valid <= 1'b1;
                r_pb           <= pwinner & (r_player_id != GUEST_ID);
                r_gb           <= (gwinner == r_player_id) &
                                  ((gwinner != 5'd0) | (r_player_id == 5'd0));
            end else if (w_show_end || w_timeout) begin
                r_result_valid <= 1'b0;
                r_pb           <= 1'b0;
                r_gb           <= 1'b0;
            end else if (r_state == S_SHOW) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (game_done && !w_drop) begin
                r_timeout_err <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Masking with valid stops the scorer re-triggering in the verdict cycle.
    assign score_request = r_req & ~valid;
    assign playerID      = r_player_id;
    assign score         = r_score;
    assign busy          = w_busy;
    assign result_valid  = r_result_valid;
    assign pb_out        = r_pb;
    assign gb_out        = r_gb;
    assign timeout_err   = r_timeout_err;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_score_requester.sv
`default_nettype none
// ============================================================================
// tb_score_requester : directed self-checking bench for score_requester
// Rev 1.0
// ============================================================================
module tb_score_requester;

    localparam int c_TIMEOUT = 16;
    localparam int c_HOLD    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_done;
    logic [4:0] game_id;
    logic [6:0] game_score;
    logic       valid;
    logic       pwinner;
    logic [4:0] gwinner;
    logic       score_request;
    logic [4:0] playerID;
    logic [6:0] score;
    logic       busy;
    logic       result_valid;
    logic       pb_out;
    logic       gb_out;
    logic       timeout_err;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    score_requester #(
        .GUEST_ID (5'd3),
        .TIMEOUT  (c_TIMEOUT),
        .HOLD     (c_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_done     (game_done),
        .game_id       (game_id),
        .game_score    (game_score),
        .valid         (valid),
        .pwinner       (pwinner),
        .gwinner       (gwinner),
        .score_request (score_request),
        .playerID      (playerID),
        .score         (score),
        .busy          (busy),
        .result_valid  (result_valid),
        .pb_out        (pb_out),
        .gb_out        (gb_out),
        .timeout_err   (timeout_err),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_bound", 32'(busy), 0);
    endtask

    // Start a game, answer after three request cycles, land in the first SHOW cycle.
    task automatic run_game(input logic [4:0] id, input logic [6:0] sc,
                            input logic pw, input logic [4:0] gw);
        game_done  = 1'b1;
        game_id    = id;
        game_score = sc;
        tick();
        game_done = 1'b0;
        check("req_up", 32'(score_request), 1);
        check("req_id", 32'(playerID), 32'(id));
        check("req_score", 32'(score), 32'(sc));
        repeat (2) tick();
        valid   = 1'b1;
        pwinner = pw;
        gwinner = gw;
        #1;
        check("req_mask", 32'(score_request), 0);
        tick();
        valid   = 1'b0;
        pwinner = 1'b0;
        gwinner = 5'd0;
        check("show_rv", 32'(result_valid), 1);
    endtask

    initial begin
        int  n;
        logic req_ok;

        rst        = 1'b1;
        game_done  = 1'b0;
        game_id    = 5'd0;
        game_score = 7'd0;
        valid      = 1'b0;
        pwinner    = 1'b0;
        gwinner    = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        check("rst_req", 32'(score_request), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_flags", 32'({pb_out, gb_out, timeout_err, overflow}), 0);
        check("rst_data", 32'({playerID, score}), 0);

        // Game 1: id 5, score 42, verdict after 8 request cycles
        game_done  = 1'b1;
        game_id    = 5'd5;
        game_score = 7'd42;
        tick();
        game_done = 1'b0;
        check("g1_req_c1", 32'(score_request), 1);
        check("g1_busy", 32'(busy), 1);
        check("g1_id", 32'(playerID), 5);
        check("g1_score", 32'(score), 42);
        req_ok = 1'b1;
        repeat (7) begin
            tick();
            if (!score_request || playerID != 5'd5) req_ok = 1'b0;
        end
        check("g1_req_held", 32'(req_ok), 1);
        valid   = 1'b1;
        pwinner = 1'b1;
        gwinner = 5'd5;
        #1;
        check("g1_req_mask", 32'(score_request), 0);
        tick();
        valid   = 1'b0;
        pwinner = 1'b0;
        gwinner = 5'd0;
        check("g1_pb", 32'(pb_out), 1);
        check("g1_gb", 32'(gb_out), 1);
        n      = 0;
        req_ok = 1'b0;
        while (result_valid && n < 100) begin
            if (score_request) req_ok = 1'b1;
            n++;
            tick();
        end
        check("g1_hold_len", 32'(n), c_HOLD);
        check("g1_no_rereq", 32'(req_ok), 0);
        check("g1_flags_clr", 32'({pb_out, gb_out}), 0);
        check("g1_idle", 32'(busy), 0);
        tick();
        check("g1_no_second", 32'(score_request), 0);

        // Guest player: personal best masked, global win still reported
        run_game(5'd3, 7'd10, 1'b0, 5'd3);
        check("g2_pb", 32'(pb_out), 0);
        check("g2_gb", 32'(gb_out), 1);
        wait_idle();
        run_game(5'd3, 7'd11, 1'b1, 5'd3);
        check("g2b_guest_pb", 32'(pb_out), 0);
        wait_idle();

        // No winner
        run_game(5'd7, 7'd20, 1'b0, 5'd0);
        check("g3_pb", 32'(pb_out), 0);
        check("g3_gb", 32'(gb_out), 0);
        wait_idle();

        // Player 0 with gwinner 0, out-of-range score forwarded
        run_game(5'd0, 7'd120, 1'b1, 5'd0);
        check("g4_pb", 32'(pb_out), 1);
        check("g4_gb", 32'(gb_out), 1);
        check("g4_score", 32'(score), 120);
        wait_idle();

        // Verdict while idle is ignored
        valid   = 1'b1;
        pwinner = 1'b1;
        gwinner = 5'd0;
        tick();
        valid   = 1'b0;
        pwinner = 1'b0;
        check("idle_valid", 32'({busy, result_valid, pb_out, gb_out}), 0);

        // Timeout: scorer never answers
        game_done  = 1'b1;
        game_id    = 5'd9;
        game_score = 7'd99;
        tick();
        game_done = 1'b0;
        n = 0;
        while (score_request && n < 100) begin
            n++;
            tick();
        end
        check("to_len", 32'(n), c_TIMEOUT);
        check("to_err", 32'(timeout_err), 1);
        check("to_busy", 32'(busy), 0);
        game_done  = 1'b1;
        game_id    = 5'd4;
        game_score = 7'd1;
        tick();
        game_done = 1'b0;
        check("to_clear", 32'(timeout_err), 0);
        check("to_rereq", 32'(score_request), 1);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_idle();

        // Pending slot: id 1 buffered, id 2 dropped
        game_done  = 1'b1;
        game_id    = 5'd10;
        game_score = 7'd50;
        tick();
        game_id    = 5'd1;
        game_score = 7'd11;
        tick();
        game_id    = 5'd2;
        game_score = 7'd22;
        tick();
        game_done = 1'b0;
        check("pend_ovf", 32'(overflow), 1);
        check("pend_stable_id", 32'(playerID), 10);
        check("pend_stable_sc", 32'(score), 50);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_idle();
        tick();
        check("pend_busy", 32'(busy), 1);
        check("pend_id", 32'(playerID), 1);
        check("pend_score", 32'(score), 11);
        check("pend_req", 32'(score_request), 1);

        // Async reset mid-request, with another event sitting in the slot
        game_done  = 1'b1;
        game_id    = 5'd6;
        game_score = 7'd66;
        tick();
        game_done = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(score_request), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_flags", 32'({result_valid, pb_out, gb_out, timeout_err, overflow}), 0);
        check("arst_id", 32'(playerID), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_slot_empty", 32'(busy), 0);
        check("arst_no_req", 32'(score_request), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
